gemm_loop_ctrl: RTL



---
 rtl/gemm_pkg.sv | 52 +++++
 rtl/gemm_loop_ctrl_if.sv | 37 +++
 rtl/gemm_issue_fifo.sv | 43 ++++
 rtl/gemm_loop_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// Shared constants for the GEMM loop sequencer: instruction/uop field positions,
// opcodes and FSM encoding.
package gemm_pkg;

  localparam int UOP_W  = 32;
  localparam int UPC_W  = 13;
  localparam int INS_W  = 128;
  localparam int ACC_W  = 11;
  localparam int INP_W  = 11;
  localparam int WGT_W  = 10;
  localparam int ITER_W = 14;

  localparam int OPCODE_LSB    = 0;
  localparam int POP_PREV_BIT  = 3;
  localparam int POP_NEXT_BIT  = 4;
  localparam int PUSH_PREV_BIT = 5;
  localparam int PUSH_NEXT_BIT = 6;
  localparam int RESET_REG_BIT = 7;
  localparam int UOP_BGN_LSB   = 8;
  localparam int UOP_END_LSB   = 21;
  localparam int ITER_OUT_LSB  = 35;
  localparam int ITER_IN_LSB   = 49;
  localparam int DST_OUT_LSB   = 63;
  localparam int DST_IN_LSB    = 74;
  localparam int SRC_OUT_LSB   = 85;
  localparam int SRC_IN_LSB    = 96;
  localparam int WGT_OUT_LSB   = 107;
  localparam int WGT_IN_LSB    = 117;

  localparam logic [2:0] OP_LOAD   = 3'd0;
  localparam logic [2:0] OP_STORE  = 3'd1;
  localparam logic [2:0] OP_GEMM   = 3'd2;
  localparam logic [2:0] OP_FINISH = 3'd3;
  localparam logic [2:0] OP_ALU    = 3'd4;

  localparam int UOP_DST_LSB = 0;
  localparam int UOP_SRC_LSB = 11;
  localparam int UOP_WGT_LSB = 22;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_DRAIN = ST_DRAIN,
    S_DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/gemm_loop_ctrl_if.sv
// Instruction, uop-buffer and issue ports of the GEMM sequencer.
// master = sequencer side, slave = environment (decoder, uop buffer, datapath).
interface gemm_loop_ctrl_if #(
  parameter int UOP_WIDTH     = 32,
  parameter int UPC_WIDTH     = 13,
  parameter int INS_WIDTH     = 128,
  parameter int ACC_IDX_WIDTH = 11,
  parameter int INP_IDX_WIDTH = 11,
  parameter int WGT_IDX_WIDTH = 10
);
  logic                     insn_valid;
  logic                     insn_ready;
  logic [INS_WIDTH-1:0]     insn;
  logic                     uop_rd_en;
  logic [UPC_WIDTH-1:0]     uop_rd_addr;
  logic [UOP_WIDTH-1:0]     uop_rd_data;
  logic                     issue_valid;
  logic                     issue_ready;
  logic [ACC_IDX_WIDTH-1:0] issue_acc_idx;
  logic [INP_IDX_WIDTH-1:0] issue_inp_idx;
  logic [WGT_IDX_WIDTH-1:0] issue_wgt_idx;
  logic                     issue_reset;
  logic                     done;
  logic [3:0]               done_flags;

  modport master (
    input  insn_valid, insn, uop_rd_data, issue_ready,
    output insn_ready, uop_rd_en, uop_rd_addr, issue_valid, issue_acc_idx,
           issue_inp_idx, issue_wgt_idx, issue_reset, done, done_flags
  );

  modport slave (
    output insn_valid, insn, uop_rd_data, issue_ready,
    input  insn_ready, uop_rd_en, uop_rd_addr, issue_valid, issue_acc_idx,
           issue_inp_idx, issue_wgt_idx, issue_reset, done, done_flags
  );
endinterface

// File: rtl/gemm_issue_fifo.sv
// Two-entry output buffer holding resolved index triples until the datapath takes them.
module gemm_issue_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/gemm_loop_ctrl.sv
// GEMM instruction sequencer: walks outer/inner/uop loops, reads uops and issues
// resolved (acc, inp, wgt) triples through a credit-limited 2-entry buffer.
//
// state | meaning
// IDLE  | insn_ready=1, waiting for an instruction
// RUN   | issuing uop reads while credit allows
// DRAIN | last read issued; waiting for in-flight read and buffer to empty
// DONE  | one-cycle done pulse
module gemm_loop_ctrl
  import gemm_pkg::*;
#(
  parameter int UOP_WIDTH     = UOP_W,
  parameter int UPC_WIDTH     = UPC_W,
  parameter int INS_WIDTH     = INS_W,
  parameter int ACC_IDX_WIDTH = ACC_W,
  parameter int INP_IDX_WIDTH = INP_W,
  parameter int WGT_IDX_WIDTH = WGT_W,
  parameter int ITER_WIDTH    = ITER_W
) (
  input  logic             clk,
  input  logic             rst_n,
  gemm_loop_ctrl_if.master bus
);
  localparam int TRIPLE_W = ACC_IDX_WIDTH + INP_IDX_WIDTH + WGT_IDX_WIDTH;

  state_e state_q, state_d;
  logic   alive_q;

  logic [INS_WIDTH-1:0]     insn_w;
  logic [UOP_WIDTH-1:0]     uop_w;
  logic [UPC_WIDTH-1:0]     f_bgn;
  logic [UPC_WIDTH:0]       f_end;
  logic [ITER_WIDTH-1:0]    f_iter_out, f_iter_in;
  logic [ACC_IDX_WIDTH-1:0] f_dst_out, f_dst_in;
  logic [INP_IDX_WIDTH-1:0] f_src_out, f_src_in;
  logic [WGT_IDX_WIDTH-1:0] f_wgt_out, f_wgt_in;
  logic                     unused_insn_bits;

  logic [UPC_WIDTH-1:0]     upc_q, bgn_q;
  logic [UPC_WIDTH:0]       end_q;
  logic [ITER_WIDTH-1:0]    rem_out_q, rem_in_q, iter_in_q;
  logic [ACC_IDX_WIDTH-1:0] dst_out_q, dst_in_q, acc_base_q, acc_off_q, acc_rd_q;
  logic [INP_IDX_WIDTH-1:0] src_out_q, src_in_q, inp_base_q, inp_off_q, inp_rd_q;
  logic [WGT_IDX_WIDTH-1:0] wgt_out_q, wgt_in_q, wgt_base_q, wgt_off_q, wgt_rd_q;
  logic [3:0]               flags_q;
  logic                     reset_reg_q;
  logic                     rd_inflight_q;

  logic                     accept, empty_insn, pop, rd_fire;
  logic                     last_upc, last_in, last_out, last_tuple;
  logic [2:0]               credit_used;
  logic [TRIPLE_W-1:0]      fifo_din, fifo_dout;
  logic [1:0]               fifo_count;
  logic                     fifo_full, fifo_empty;

  assign insn_w     = bus.insn;
  assign uop_w      = bus.uop_rd_data;
  assign f_bgn      = insn_w[UOP_BGN_LSB +: UPC_WIDTH];
  assign f_end      = insn_w[UOP_END_LSB +: UPC_WIDTH + 1];
  assign f_iter_out = insn_w[ITER_OUT_LSB +: ITER_WIDTH];
  assign f_iter_in  = insn_w[ITER_IN_LSB +: ITER_WIDTH];
  assign f_dst_out  = insn_w[DST_OUT_LSB +: ACC_IDX_WIDTH];
  assign f_dst_in   = insn_w[DST_IN_LSB +: ACC_IDX_WIDTH];
  assign f_src_out  = insn_w[SRC_OUT_LSB +: INP_IDX_WIDTH];
  assign f_src_in   = insn_w[SRC_IN_LSB +: INP_IDX_WIDTH];
  assign f_wgt_out  = insn_w[WGT_OUT_LSB +: WGT_IDX_WIDTH];
  assign f_wgt_in   = insn_w[WGT_IN_LSB +: WGT_IDX_WIDTH];
  // Opcode is decoded upstream; the top bit is a spare.
  assign unused_insn_bits = ^{insn_w[OPCODE_LSB +: 3], insn_w[INS_WIDTH-1]};

  assign accept     = bus.insn_valid && bus.insn_ready;
  assign empty_insn = (f_iter_out == '0) || (f_iter_in == '0) || (f_end <= {1'b0, f_bgn});
  assign pop        = bus.issue_valid && bus.issue_ready;

  assign last_upc   = (({1'b0, upc_q} + (UPC_WIDTH + 1)'(1)) == end_q);
  assign last_in    = (rem_in_q == ITER_WIDTH'(1));
  assign last_out   = (rem_out_q == ITER_WIDTH'(1));
  assign last_tuple = last_upc && last_in && last_out;

  // An entry leaving this cycle frees its slot, which keeps one triple per cycle.
  assign credit_used = {1'b0, fifo_count} + {2'b00, rd_inflight_q};
  assign rd_fire     = (state_q == S_RUN) && (credit_used < (3'd2 + {2'b00, pop}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = empty_insn ? S_DONE : S_RUN;
      S_RUN:   if (rd_fire && last_tuple) state_d = S_DRAIN;
      S_DRAIN: if (!rd_inflight_q && (fifo_empty || (!fifo_full && pop))) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upc_q <= '0; bgn_q <= '0; end_q <= '0;
      rem_out_q <= '0; rem_in_q <= '0; iter_in_q <= '0;
      dst_out_q <= '0; dst_in_q <= '0; acc_base_q <= '0; acc_off_q <= '0;
      src_out_q <= '0; src_in_q <= '0; inp_base_q <= '0; inp_off_q <= '0;
      wgt_out_q <= '0; wgt_in_q <= '0; wgt_base_q <= '0; wgt_off_q <= '0;
      flags_q <= '0; reset_reg_q <= 1'b0;
    end else if (accept) begin
      upc_q <= f_bgn; bgn_q <= f_bgn; end_q <= f_end;
      rem_out_q <= f_iter_out; rem_in_q <= f_iter_in; iter_in_q <= f_iter_in;
      dst_out_q <= f_dst_out; dst_in_q <= f_dst_in; acc_base_q <= '0; acc_off_q <= '0;
      src_out_q <= f_src_out; src_in_q <= f_src_in; inp_base_q <= '0; inp_off_q <= '0;
      wgt_out_q <= f_wgt_out; wgt_in_q <= f_wgt_in; wgt_base_q <= '0; wgt_off_q <= '0;
      flags_q     <= insn_w[POP_PREV_BIT +: 4];
      reset_reg_q <= insn_w[RESET_REG_BIT];
    end else if (rd_fire) begin
      if (last_upc) begin
        upc_q <= bgn_q;
        if (last_in) begin
          rem_in_q   <= iter_in_q;
          rem_out_q  <= rem_out_q - ITER_WIDTH'(1);
          acc_base_q <= acc_base_q + dst_out_q;
          acc_off_q  <= acc_base_q + dst_out_q;
          inp_base_q <= inp_base_q + src_out_q;
          inp_off_q  <= inp_base_q + src_out_q;
          wgt_base_q <= wgt_base_q + wgt_out_q;
          wgt_off_q  <= wgt_base_q + wgt_out_q;
        end else begin
          rem_in_q  <= rem_in_q - ITER_WIDTH'(1);
          acc_off_q <= acc_off_q + dst_in_q;
          inp_off_q <= inp_off_q + src_in_q;
          wgt_off_q <= wgt_off_q + wgt_in_q;
        end
      end else begin
        upc_q <= upc_q + UPC_WIDTH'(1);
      end
    end
  end

  // Offsets ride alongside the read so they pair with the returning uop word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_inflight_q <= 1'b0;
      acc_rd_q <= '0; inp_rd_q <= '0; wgt_rd_q <= '0;
    end else begin
      rd_inflight_q <= rd_fire;
      if (rd_fire) begin
        acc_rd_q <= acc_off_q;
        inp_rd_q <= inp_off_q;
        wgt_rd_q <= wgt_off_q;
      end
    end
  end

  assign fifo_din = {uop_w[UOP_WGT_LSB +: WGT_IDX_WIDTH] + wgt_rd_q,
                     uop_w[UOP_SRC_LSB +: INP_IDX_WIDTH] + inp_rd_q,
                     uop_w[UOP_DST_LSB +: ACC_IDX_WIDTH] + acc_rd_q};

  gemm_issue_fifo #(.WIDTH(TRIPLE_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_inflight_q),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.insn_ready  = alive_q && (state_q == S_IDLE);
  assign bus.uop_rd_en   = rd_fire;
  assign bus.uop_rd_addr = upc_q;
  assign bus.issue_valid = !fifo_empty;
  assign {bus.issue_wgt_idx, bus.issue_inp_idx, bus.issue_acc_idx} = fifo_dout;
  assign bus.issue_reset = reset_reg_q;
  assign bus.done        = (state_q == S_DONE);
  assign bus.done_flags  = flags_q;
endmodule
